// File: rtl/fetch_queue_unit.sv
// Instruction-fetch stage: owns the PC, issues reads to a 1-cycle synchronous
// program memory, buffers returned words in a small FIFO and presents the
// head entry to decode over a valid/ready handshake. A redirect flushes the
// FIFO, squashes the in-flight response and restarts fetch at the target.
module fetch_queue_unit #(
  parameter int                ADDR_W   = 8,
  parameter int                INS_W    = 24,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     redirect_valid,
  input  logic [ADDR_W-1:0]        redirect_addr,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic                     mem_rd_en,
  input  logic [INS_W-1:0]         mem_rdata,
  output logic [INS_W-1:0]         ins,
  output logic [ADDR_W-1:0]        ins_addr,
  output logic                     ins_valid,
  input  logic                     ins_ready,
  output logic [$clog2(DEPTH):0]   queue_count,
  output logic [ADDR_W-1:0]        pc_out
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] pc;
  logic              rsp_pending;
  logic [ADDR_W-1:0] rsp_addr;

  logic [INS_W-1:0]  fifo_ins  [DEPTH];
  logic [ADDR_W-1:0] fifo_addr [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;

  logic              push;
  logic              pop;
  logic [CNT_W:0]    inflight;

  // Issue decision: a redirect always fetches its target; otherwise fetch
  // only while buffered plus outstanding words leave room in the FIFO.
  // NOTE: every output of an always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    inflight  = {1'b0, count} + {{CNT_W{1'b0}}, rsp_pending};
    mem_addr  = redirect_valid ? redirect_addr : pc;
    mem_rd_en = 1'b0;
    if (reset) begin
      mem_rd_en = redirect_valid || (inflight < (CNT_W+1)'(DEPTH));
    end
  end

  // Handshake qualifiers; a redirect overrides both the response and the pop.
  always_comb begin
    push      = rsp_pending && !redirect_valid;
    ins_valid = (count != '0);
    pop       = ins_valid && ins_ready && !redirect_valid;
    ins       = ins_valid ? fifo_ins[rd_ptr]  : '0;
    ins_addr  = ins_valid ? fifo_addr[rd_ptr] : '0;
  end

  assign queue_count = count;
  assign pc_out      = pc;

  // PC advance and tracking of the single outstanding memory read.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement or process order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc          <= RESET_PC;
      rsp_pending <= 1'b0;
      rsp_addr    <= '0;
    end else begin
      rsp_pending <= mem_rd_en;
      rsp_addr    <= mem_addr;
      if (mem_rd_en) begin
        pc <= mem_addr + 1'b1;
      end
    end
  end

  // FIFO storage writes at the tail when a response is accepted.
  // NOTE: the storage array is deliberately not reset; an entry is only
  // visible once count covers it, and ins/ins_addr are masked when empty.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_ins[wr_ptr]  <= mem_rdata;
      fifo_addr[wr_ptr] <= rsp_addr;
    end
  end

  // FIFO pointers and occupancy; a redirect empties the queue outright.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // The issue rule reserves a slot for every outstanding read, so a push
  // into a full queue means the reservation logic is broken.
  a_no_overflow : assert property (@(posedge clk) disable iff (!reset)
    !(push && count == CNT_W'(DEPTH)));

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: a queue-based model of the fetch stage is
// compared against the DUT on every falling edge, and a set of directed
// scenarios pins the model with hand-computed literal expectations.
module tb_fetch_queue_unit;

  localparam int ADDR_W = 8;
  localparam int INS_W  = 24;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_addr;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [INS_W-1:0]  mem_rdata = '0;
  logic [INS_W-1:0]  ins;
  logic [ADDR_W-1:0] ins_addr;
  logic              ins_valid;
  logic              ins_ready;
  logic [2:0]        queue_count;
  logic [ADDR_W-1:0] pc_out;

  int errors = 0;
  int checks = 0;

  logic [INS_W-1:0] mem_words [256];

  typedef struct {
    logic [INS_W-1:0]  ins;
    logic [ADDR_W-1:0] addr;
  } ent_t;

  // Model state: buffered instructions, the outstanding read, and the PC.
  ent_t              q[$];
  bit                m_pend      = 1'b0;
  logic [ADDR_W-1:0] m_pend_addr = '0;
  logic [ADDR_W-1:0] m_pc        = '0;

  fetch_queue_unit #(
    .ADDR_W  (ADDR_W),
    .INS_W   (INS_W),
    .DEPTH   (DEPTH),
    .RESET_PC(8'h00)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .redirect_valid(redirect_valid),
    .redirect_addr (redirect_addr),
    .mem_addr      (mem_addr),
    .mem_rd_en     (mem_rd_en),
    .mem_rdata     (mem_rdata),
    .ins           (ins),
    .ins_addr      (ins_addr),
    .ins_valid     (ins_valid),
    .ins_ready     (ins_ready),
    .queue_count   (queue_count),
    .pc_out        (pc_out)
  );

  always #5 clk = ~clk;

  // Synchronous-read program memory with one cycle of latency.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem_words[mem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: advance one cycle from the rules of the fetch stage.
  always @(posedge clk or negedge reset) begin
    bit                rd;
    logic [ADDR_W-1:0] ad;
    if (!reset) begin
      q.delete();
      m_pend      = 1'b0;
      m_pend_addr = '0;
      m_pc        = 8'h00;
    end else begin
      rd = redirect_valid || (q.size() + int'(m_pend) < DEPTH);
      ad = redirect_valid ? redirect_addr : m_pc;
      if (redirect_valid) begin
        q.delete();
      end else begin
        if (q.size() > 0 && ins_ready) void'(q.pop_front());
        if (m_pend) q.push_back('{ins: mem_words[m_pend_addr], addr: m_pend_addr});
      end
      m_pend      = rd;
      m_pend_addr = ad;
      if (rd) m_pc = ad + 8'd1;
    end
  end

  // Compare process: every falling edge, DUT outputs against the model.
  always @(negedge clk) begin
    bit exp_rd;
    if (!reset) begin
      check("rst_mem_rd_en", 32'(mem_rd_en), 32'(0));
      check("rst_ins_valid", 32'(ins_valid), 32'(0));
      check("rst_ins", 32'(ins), 32'(0));
      check("rst_ins_addr", 32'(ins_addr), 32'(0));
      check("rst_queue_count", 32'(queue_count), 32'(0));
      check("rst_pc_out", 32'(pc_out), 32'(0));
    end else begin
      exp_rd = redirect_valid || (q.size() + int'(m_pend) < DEPTH);
      check("mem_rd_en", 32'(mem_rd_en), 32'(exp_rd));
      check("mem_addr", 32'(mem_addr), 32'(redirect_valid ? redirect_addr : m_pc));
      check("pc_out", 32'(pc_out), 32'(m_pc));
      check("queue_count", 32'(queue_count), 32'(q.size()));
      check("ins_valid", 32'(ins_valid), 32'(q.size() > 0));
      if (q.size() > 0) begin
        check("ins", 32'(ins), 32'(q[0].ins));
        check("ins_addr", 32'(ins_addr), 32'(q[0].addr));
      end else begin
        check("ins_empty", 32'(ins), 32'(0));
        check("ins_addr_empty", 32'(ins_addr), 32'(0));
      end
    end
  end

  // One cycle: let the next rising edge happen, then set the inputs it
  // leaves behind for the following edge.
  task automatic tick(input logic r, input logic [ADDR_W-1:0] a, input logic rdy);
    @(posedge clk);
    #2;
    redirect_valid = r;
    redirect_addr  = a;
    ins_ready      = rdy;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 256; k++) mem_words[k] = 24'(k + 'h100);
    reset          = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr  = '0;
    ins_ready      = 1'b1;

    // Held in reset.
    #1;
    check("lit_rst_valid", 32'(ins_valid), 32'(0));
    check("lit_rst_rd_en", 32'(mem_rd_en), 32'(0));
    check("lit_rst_count", 32'(queue_count), 32'(0));
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;

    // Release: fetch 0,1,2,... and deliver 0x100,0x101,... two cycles later.
    #1;
    check("lit_rel_rd_en", 32'(mem_rd_en), 32'(1));
    check("lit_rel_addr0", 32'(mem_addr), 32'(8'h00));
    tick(1'b0, 8'h00, 1'b1); #1;
    check("lit_rel_addr1", 32'(mem_addr), 32'(8'h01));
    check("lit_rel_not_valid", 32'(ins_valid), 32'(0));
    tick(1'b0, 8'h00, 1'b1); #1;
    check("lit_first_valid", 32'(ins_valid), 32'(1));
    check("lit_first_addr", 32'(ins_addr), 32'(8'h00));
    check("lit_first_ins", 32'(ins), 32'(24'h100));
    tick(1'b0, 8'h00, 1'b1); #1;
    check("lit_second_addr", 32'(ins_addr), 32'(8'h01));
    check("lit_second_ins", 32'(ins), 32'(24'h101));
    check("lit_steady_count", 32'(queue_count), 32'(1));

    // Redirect to 0x40 with three entries buffered and a read in flight.
    tick(1'b0, 8'h00, 1'b0);
    tick(1'b0, 8'h00, 1'b0);
    tick(1'b1, 8'h40, 1'b1); #1;
    check("lit_pre_redir_count", 32'(queue_count), 32'(3));
    check("lit_redir_addr", 32'(mem_addr), 32'(8'h40));
    tick(1'b0, 8'h00, 1'b1); #1;
    check("lit_flush_count", 32'(queue_count), 32'(0));
    check("lit_flush_valid", 32'(ins_valid), 32'(0));
    tick(1'b0, 8'h00, 1'b1); #1;
    check("lit_target_addr", 32'(ins_addr), 32'(8'h40));
    check("lit_target_ins", 32'(ins), 32'(24'h140));
    tick(1'b0, 8'h00, 1'b1); #1;
    check("lit_target_next", 32'(ins_addr), 32'(8'h41));

    // Stall: queue fills to DEPTH, fetch stops, head frozen at 0x42.
    repeat (11) tick(1'b0, 8'h00, 1'b0);
    #1;
    check("lit_stall_count", 32'(queue_count), 32'(4));
    check("lit_stall_rd_en", 32'(mem_rd_en), 32'(0));
    check("lit_stall_head", 32'(ins_addr), 32'(8'h42));
    check("lit_stall_ins", 32'(ins), 32'(24'h142));
    repeat (8) tick(1'b0, 8'h00, 1'b1);

    // Redirect racing a handshake, then back-to-back redirects 0x10, 0x20.
    tick(1'b1, 8'h10, 1'b1); #1;
    check("lit_hs_valid", 32'(ins_valid), 32'(1));
    tick(1'b1, 8'h20, 1'b1); #1;
    check("lit_hs_flush", 32'(queue_count), 32'(0));
    tick(1'b0, 8'h00, 1'b1); #1;
    check("lit_b2b_empty", 32'(ins_valid), 32'(0));
    tick(1'b0, 8'h00, 1'b1); #1;
    check("lit_b2b_addr", 32'(ins_addr), 32'(8'h20));
    check("lit_b2b_ins", 32'(ins), 32'(24'h120));
    tick(1'b0, 8'h00, 1'b1); #1;
    check("lit_b2b_next", 32'(ins_addr), 32'(8'h21));

    // PC wrap from 0xFE, then redirect to 0xFF.
    tick(1'b1, 8'hFE, 1'b1); #1;
    check("lit_wrap_fe", 32'(mem_addr), 32'(8'hFE));
    tick(1'b0, 8'h00, 1'b1); #1;
    check("lit_wrap_ff", 32'(mem_addr), 32'(8'hFF));
    check("lit_wrap_pc", 32'(pc_out), 32'(8'hFF));
    tick(1'b0, 8'h00, 1'b1); #1;
    check("lit_wrap_00", 32'(mem_addr), 32'(8'h00));
    tick(1'b0, 8'h00, 1'b1); #1;
    check("lit_wrap_01", 32'(mem_addr), 32'(8'h01));
    tick(1'b1, 8'hFF, 1'b1);
    tick(1'b0, 8'h00, 1'b1); #1;
    check("lit_redir_ff_next", 32'(mem_addr), 32'(8'h00));
    check("lit_redir_ff_pc", 32'(pc_out), 32'(8'h00));

    // Reset asserted mid-operation with three entries queued.
    tick(1'b1, 8'h80, 1'b1);
    tick(1'b0, 8'h00, 1'b1);
    tick(1'b0, 8'h00, 1'b0);
    tick(1'b0, 8'h00, 1'b0);
    tick(1'b0, 8'h00, 1'b0); #1;
    check("lit_mid_count3", 32'(queue_count), 32'(3));
    reset = 1'b0;
    #1;
    check("lit_mid_valid", 32'(ins_valid), 32'(0));
    check("lit_mid_ins", 32'(ins), 32'(0));
    check("lit_mid_count", 32'(queue_count), 32'(0));
    check("lit_mid_pc", 32'(pc_out), 32'(0));
    for (int k = 0; k < 256; k++) mem_words[k] = 24'($urandom);
    ins_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("lit_restart_addr", 32'(mem_addr), 32'(8'h00));
    check("lit_restart_rd_en", 32'(mem_rd_en), 32'(1));
    tick(1'b0, 8'h00, 1'b1);
    tick(1'b0, 8'h00, 1'b1); #1;
    check("lit_restart_head", 32'(ins_addr), 32'(8'h00));
    check("lit_restart_ins", 32'(ins), 32'(mem_words[0]));

    // Randomized traffic: sparse redirects, frequent stalls.
    for (int n = 0; n < 600; n++) begin
      tick($urandom_range(0, 9) == 0, 8'($urandom), $urandom_range(0, 3) != 0);
    end
    repeat (4) tick(1'b0, 8'h00, 1'b1);

    @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
Parametrised instruction-fetch stage that succeeds the fixed 8-bit PC/instruction-memory block. It owns the program counter and drives a synchronous-read program memory with 1-cycle read latency. Fetched instructions are buffered in a DEPTH-entry FIFO and handed to decode over a valid/ready handshake. Jump/branch redirects flush the FIFO and squash any in-flight read.

Parameters:
ADDR_W, 8, program-counter / memory address width
INS_W, 24, instruction width
DEPTH, 4, FIFO entries; power of two, >= 4
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low; 0 = held in reset
redirect_valid  in  1  jump/branch taken this cycle
redirect_addr  in  ADDR_W  jump target
mem_addr  out  ADDR_W  program memory read address (combinational)
mem_rd_en  out  1  read request this cycle (combinational)
mem_rdata  in  INS_W  memory data, valid the cycle after the request
ins  out  INS_W  FIFO head instruction; 0 (NOP) when ins_valid=0
ins_addr  out  ADDR_W  address of the head instruction; 0 when ins_valid=0
ins_valid  out  1  head entry present
ins_ready  in  1  decode accepts head; 0 = stall
queue_count  out  $clog2(DEPTH)+1  current FIFO occupancy
pc_out  out  ADDR_W  current PC register

Behaviour:
- Reset (reset=0, async): pc=RESET_PC, FIFO empty, rsp_pending=0, queue_count=0, ins_valid=0, ins=0, ins_addr=0, mem_rd_en=0. Outputs hold these values for the whole reset assertion.
- Issue rule, no redirect: mem_rd_en = (queue_count + rsp_pending < DEPTH). This rule is conservative and ignores a same-cycle pop. When issuing, mem_addr=pc and pc <= pc+1 (mod 2^ADDR_W, wraps from all-ones to 0). When not issuing, mem_addr=pc and pc holds.
- Issue rule, redirect_valid=1: mem_rd_en=1 unconditionally, mem_addr=redirect_addr, pc <= redirect_addr+1 (mod 2^ADDR_W).
- rsp_pending <= mem_rd_en, together with a registered copy of mem_addr (rsp_addr).
- Push: when rsp_pending=1 and redirect_valid=0, write {mem_rdata, rsp_addr} into the FIFO tail.
- Squash: a response arriving in a cycle with redirect_valid=1 is discarded.
- Pop: when ins_valid & ins_ready & !redirect_valid.
- Simultaneous push and pop: queue_count is unchanged; the read pointer and write pointer each advance.
- Redirect flush: queue_count <= 0 and pointers reset. A head handshake in the same cycle is ignored; redirect has priority.
- Overflow is impossible by the issue rule. Push when full is a protocol violation; it is flagged by an assertion only.
- Latency:
  - Redirect in cycle t: read at target in t, push in t+1, ins_valid with the target in t+2.
  - From reset release: first mem_rd_en in the first cycle after release, first ins_valid 2 cycles later.
- Throughput: with ins_ready=1 and no redirects, one instruction per cycle sustained after a 2-cycle fill.
- Stall (ins_ready=0): the FIFO fills to DEPTH and then mem_rd_en drops. Head ins and ins_addr stay stable while stalled.
- ins, ins_addr and ins_valid are driven from FIFO registers/pointers only. There is no combinational path from mem_rdata to ins.
- Reset asserted mid-operation: all state clears immediately. The pending read response is ignored.

Test Plan:
- Reset release with RESET_PC=0, ins_ready=1, memory word[k]=k+0x100 -> mem_addr 0,1,2,... on consecutive cycles; ins 0x100,0x101,... with ins_addr 0,1,... from 2 cycles after release; one instruction per cycle.
- ins_ready=0 from cycle 5 for 10 cycles -> queue_count saturates at 4 and mem_rd_en=0 while full; ins/ins_addr frozen. On release, instructions resume in order with none lost or duplicated.
- redirect_valid with redirect_addr=0x40 while the FIFO holds 3 entries and a read is in flight -> queue_count=0 next cycle, in-flight data dropped; ins_addr=0x40 two cycles later, then 0x41.
- Redirect in the same cycle as ins_valid & ins_ready -> no pop counted, FIFO flushed. Back-to-back redirects to 0x10 then 0x20 -> only 0x20 stream appears.
- PC at 0xFE, free-running -> fetch addresses 0xFE, 0xFF, 0x00, 0x01. Redirect to 0xFF -> next fetch 0x00.
- Assert reset while queue_count=3 -> ins_valid=0, ins=0 and queue_count=0 immediately without a clock edge. After release, fetch restarts at RESET_PC.
